// File: rtl/btb_port_arb_if.sv
// btb_port_arb_if: lookup, update and SRAM signal bundle for btb_port_arb.
// The slave modport is the arbiter side; the master modport is the
// frontend/backend/SRAM-model side.
interface btb_port_arb_if;
    logic         lkp_req_valid;
    logic [8:0]   lkp_req_index;
    logic         lkp_req_ready;
    logic         lkp_resp_valid;
    logic [8:0]   lkp_resp_index;
    logic         redirect_valid;
    logic         upd_valid;
    logic         upd_ready;
    logic [8:0]   upd_index;
    logic [128:0] upd_wmask;
    logic [128:0] upd_din;
    logic         sram_ce;
    logic         sram_we;
    logic [8:0]   sram_addr;
    logic [128:0] sram_wmask;
    logic [128:0] sram_din;

    modport master (
        output lkp_req_valid, lkp_req_index, redirect_valid,
        output upd_valid, upd_index, upd_wmask, upd_din,
        input  lkp_req_ready, lkp_resp_valid, lkp_resp_index, upd_ready,
        input  sram_ce, sram_we, sram_addr, sram_wmask, sram_din
    );

    modport slave (
        input  lkp_req_valid, lkp_req_index, redirect_valid,
        input  upd_valid, upd_index, upd_wmask, upd_din,
        output lkp_req_ready, lkp_resp_valid, lkp_resp_index, upd_ready,
        output sram_ce, sram_we, sram_addr, sram_wmask, sram_din
    );
endinterface

// File: rtl/btb_port_arb.sv
// btb_port_arb: shares one single-port BTB SRAM between frontend lookups and
// queued backend updates. Lookups normally win; an update that has been
// denied STARVE_LIMIT times in a row is forced through for one cycle.
// Optional feature macro: BTB_PORT_ARB_PERF_EN adds saturating counters
// perf_lkp_block_cnt and perf_upd_force_cnt.
module btb_port_arb #(
    parameter int UPD_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    btb_port_arb_if.slave bus
`ifdef BTB_PORT_ARB_PERF_EN
    ,
    output logic [31:0]   perf_lkp_block_cnt,
    output logic [31:0]   perf_upd_force_cnt
`endif
);
    localparam int IDX_W  = 9;
    localparam int DATA_W = 129;
    localparam int PTR_W  = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CNT_W  = $clog2(UPD_DEPTH) + 1;
    localparam int STV_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UPD_DEPTH);

    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_FORCE_UPD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_q_index [UPD_DEPTH];
    logic [DATA_W-1:0]  r_q_wmask [UPD_DEPTH];
    logic [DATA_W-1:0]  r_q_din   [UPD_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [STV_W-1:0]   r_starve;
    logic               r_resp_vld_p1;
    logic [IDX_W-1:0]   r_resp_index_p1;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_lkp_ready;
    logic               w_grant;
    logic               w_wr_issue;
    logic               w_denied;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    // Updates offered during reset are acknowledged but dropped with the queue.
    assign w_push   = bus.upd_valid && !w_full && !reset;
    assign w_denied = !w_empty && !w_wr_issue;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_NORMAL;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: force one write after the head has starved long enough
    always_comb begin
        w_state_nxt = ST_NORMAL;
        case (r_state)
            ST_NORMAL:    if (w_denied && (r_starve == STV_MAX)) w_state_nxt = ST_FORCE_UPD;
            default:      w_state_nxt = ST_NORMAL;
        endcase
    end

    // FSM outputs: port arbitration and SRAM command; everything idle in reset
    always_comb begin
        w_lkp_ready = 1'b0;
        w_wr_issue  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_NORMAL: begin
                    w_lkp_ready = !bus.redirect_valid;
                    w_wr_issue  = !w_empty && !(bus.lkp_req_valid && !bus.redirect_valid);
                end
                default: begin
                    w_lkp_ready = 1'b0;
                    w_wr_issue  = !w_empty;
                end
            endcase
        end
        w_grant            = bus.lkp_req_valid && w_lkp_ready;
        bus.lkp_req_ready  = w_lkp_ready;
        bus.upd_ready      = !w_full || reset;
        bus.sram_ce        = w_grant || w_wr_issue;
        bus.sram_we        = w_wr_issue;
        bus.sram_addr      = '0;
        bus.sram_wmask     = '0;
        bus.sram_din       = '0;
        if (w_wr_issue) begin
            bus.sram_addr  = r_q_index[r_rd_ptr];
            bus.sram_wmask = r_q_wmask[r_rd_ptr];
            bus.sram_din   = r_q_din[r_rd_ptr];
        end else if (w_grant) begin
            bus.sram_addr  = bus.lkp_req_index;
        end
        bus.lkp_resp_valid = r_resp_vld_p1;
        bus.lkp_resp_index = r_resp_vld_p1 ? r_resp_index_p1 : '0;
    end

    // Starve counter: consecutive cycles the queue head waited, held at the limit
    always_ff @(posedge clock) begin
        if (reset)                       r_starve <= '0;
        else if (w_empty || w_wr_issue)  r_starve <= '0;
        else if (r_starve != STV_MAX)    r_starve <= r_starve + STV_W'(1);
    end

    // Update queue pointers and occupancy; pointers wrap naturally at UPD_DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_wr_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_wr_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Update queue payload storage
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_index[r_wr_ptr] <= bus.upd_index;
            r_q_wmask[r_wr_ptr] <= bus.upd_wmask;
            r_q_din[r_wr_ptr]   <= bus.upd_din;
        end
    end

    // ---- stage p0 -> p1: SRAM read returns one cycle after the grant ----
    // Read-response valid
    always_ff @(posedge clock) begin
        if (reset) r_resp_vld_p1 <= 1'b0;
        else       r_resp_vld_p1 <= w_grant;
    end

    // Read-response index
    always_ff @(posedge clock) begin
        r_resp_index_p1 <= bus.lkp_req_index;
    end

`ifdef BTB_PORT_ARB_PERF_EN
    logic [31:0] r_perf_blk;
    logic [31:0] r_perf_frc;

    // Saturating counts of blocked lookups and forced-update entries
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_blk <= '0;
            r_perf_frc <= '0;
        end else begin
            if (bus.lkp_req_valid && !w_lkp_ready && (r_perf_blk != '1))
                r_perf_blk <= r_perf_blk + 32'd1;
            if ((r_state == ST_NORMAL) && (w_state_nxt == ST_FORCE_UPD) && (r_perf_frc != '1))
                r_perf_frc <= r_perf_frc + 32'd1;
        end
    end

    assign perf_lkp_block_cnt = r_perf_blk;
    assign perf_upd_force_cnt = r_perf_frc;
`endif
endmodule

// File: tb/tb_btb_port_arb.sv
// tb_btb_port_arb: directed scenarios followed by randomized traffic, each
// cycle compared against a queue-based reference model of the arbiter.
module tb_btb_port_arb;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [8:0]   idx;
        logic [128:0] m;
        logic [128:0] d;
    } upd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    btb_port_arb_if bus();

`ifdef BTB_PORT_ARB_PERF_EN
    logic [31:0] perf_blk;
    logic [31:0] perf_frc;
    int          m_blk = 0;
    int          m_frc = 0;
`endif

    btb_port_arb #(.UPD_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef BTB_PORT_ARB_PERF_EN
        ,
        .perf_lkp_block_cnt (perf_blk),
        .perf_upd_force_cnt (perf_frc)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    upd_t       mq[$];
    int         m_starve = 0;
    bit         m_force  = 0;
    bit         m_resp_vld = 0;
    logic [8:0] m_resp_idx = '0;
    logic [8:0] wr_log[$];

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] rnd129();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[128:0];
    endfunction

    task automatic drive(input bit lv, input logic [8:0] li, input bit rd,
                         input bit uv, input logic [8:0] ui);
        bus.lkp_req_valid  = lv;
        bus.lkp_req_index  = li;
        bus.redirect_valid = rd;
        bus.upd_valid      = uv;
        bus.upd_index      = ui;
        bus.upd_wmask      = rnd129();
        bus.upd_din        = rnd129();
    endtask

    // Reference model: evaluates the current cycle's outputs from the
    // arbitration rules, then advances its own state to the next cycle.
    task automatic model_cycle();
        bit   grant, wr, rdy, denied, nforce;
        int   qn;
        upd_t h;
        upd_t n;
        qn = mq.size();
        chk("resp_vld", bus.lkp_resp_valid, m_resp_vld);
        if (m_resp_vld) chk("resp_idx", bus.lkp_resp_index, m_resp_idx);
        if (reset) begin
            chk("rst_ready", bus.lkp_req_ready, 0);
            chk("rst_upd_ready", bus.upd_ready, 1);
            chk("rst_ce", bus.sram_ce, 0);
            chk("rst_we", bus.sram_we, 0);
            mq.delete();
            m_starve   = 0;
            m_force    = 0;
            m_resp_vld = 0;
            return;
        end
        chk("upd_ready", bus.upd_ready, qn < DEPTH);
        if (m_force) begin
            rdy = 0; grant = 0; wr = (qn > 0);
        end else begin
            rdy = !bus.redirect_valid;
            grant = bus.lkp_req_valid && rdy;
            wr = !grant && (qn > 0);
        end
        chk("ready", bus.lkp_req_ready, rdy);
        chk("ce", bus.sram_ce, grant || wr);
        chk("we", bus.sram_we, wr);
        if (wr) begin
            h = mq[0];
            chk("wr_addr", bus.sram_addr, h.idx);
            chk("wr_wmask", bus.sram_wmask, h.m);
            chk("wr_din", bus.sram_din, h.d);
            wr_log.push_back(h.idx);
        end else if (grant) begin
            chk("rd_addr", bus.sram_addr, bus.lkp_req_index);
            chk("rd_wmask", bus.sram_wmask, 0);
        end
`ifdef BTB_PORT_ARB_PERF_EN
        if (bus.lkp_req_valid && !rdy) m_blk++;
`endif
        denied  = (qn > 0) && !wr;
        nforce  = !m_force && denied && (m_starve == LIMIT - 1);
`ifdef BTB_PORT_ARB_PERF_EN
        if (nforce) m_frc++;
`endif
        m_force = nforce;
        if (qn == 0 || wr)          m_starve = 0;
        else if (m_starve < LIMIT-1) m_starve = m_starve + 1;
        if (wr) void'(mq.pop_front());
        if (bus.upd_valid && qn < DEPTH) begin
            n.idx = bus.upd_index; n.m = bus.upd_wmask; n.d = bus.upd_din;
            mq.push_back(n);
        end
        m_resp_vld = grant;
        m_resp_idx = bus.lkp_req_index;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic adv();
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        bit acc;
        drive(0, 9'h000, 0, 0, 9'h000);
        // Reset: first edge clears state, then check the reset-cycle outputs
        reset = 1'b1;
        @(posedge clock); #1;
        settle();
        chk("reset_ready", bus.lkp_req_ready, 0);
        chk("reset_resp_vld", bus.lkp_resp_valid, 0);
        chk("reset_resp_idx", bus.lkp_resp_index, 0);
        chk("reset_upd_ready", bus.upd_ready, 1);
        chk("reset_ce", bus.sram_ce, 0);
        chk("reset_we", bus.sram_we, 0);
        chk("reset_addr", bus.sram_addr, 0);
        chk("reset_wmask", bus.sram_wmask, 0);
        chk("reset_din", bus.sram_din, 0);
        adv();
        reset = 1'b0;

        // Lookup 0x05 with empty queue
        drive(1, 9'h005, 0, 0, 9'h000);
        settle();
        chk("lkp_ready", bus.lkp_req_ready, 1);
        chk("lkp_ce", bus.sram_ce, 1);
        chk("lkp_we", bus.sram_we, 0);
        chk("lkp_addr", bus.sram_addr, 9'h005);
        adv();
        drive(0, 9'h000, 0, 0, 9'h000);
        settle();
        chk("lkp_resp_vld", bus.lkp_resp_valid, 1);
        chk("lkp_resp_idx", bus.lkp_resp_index, 9'h005);
        adv();

        // Single update 0x1A, written the following cycle
        drive(0, 9'h000, 0, 1, 9'h01A);
        settle();
        chk("upd_accept", bus.upd_ready, 1);
        chk("upd_no_bypass", bus.sram_we, 0);
        adv();
        drive(0, 9'h000, 0, 0, 9'h000);
        settle();
        chk("upd_we", bus.sram_we, 1);
        chk("upd_addr", bus.sram_addr, 9'h01A);
        adv();
        settle();
        chk("upd_drained_ready", bus.upd_ready, 1);
        chk("upd_drained_ce", bus.sram_ce, 0);
        adv();

        // Starvation: 4 granted lookups, one forced write, lookups resume
        drive(1, 9'h033, 0, 1, 9'h00C);
        cyc();
        bus.upd_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk("starve_lkp_ready", bus.lkp_req_ready, 1);
            chk("starve_lkp_we", bus.sram_we, 0);
            adv();
        end
        settle();
        chk("force_ready", bus.lkp_req_ready, 0);
        chk("force_we", bus.sram_we, 1);
        chk("force_addr", bus.sram_addr, 9'h00C);
        adv();
        settle();
        chk("resume_ready", bus.lkp_req_ready, 1);
        chk("resume_we", bus.sram_we, 0);
        chk("resume_ce", bus.sram_ce, 1);
        adv();

        // Full queue back-pressure and in-order writes under saturating lookups
        wr_log.delete();
        drive(1, 9'h044, 0, 1, 9'h0A1);
        cyc();
        drive(1, 9'h045, 0, 1, 9'h0A2);
        cyc();
        drive(1, 9'h046, 0, 1, 9'h0A3);
        acc = 0;
        for (int n = 0; n < 40 && !acc; n++) begin
            settle();
            if (n == 0) chk("full_upd_ready", bus.upd_ready, 0);
            if (bus.upd_ready) begin
                acc = 1;
                chk("full_first_written", wr_log.size(), 1);
            end
            adv();
        end
        chk("full_third_accepted", acc, 1);
        bus.upd_valid = 0;
        for (int n = 0; n < 30; n++) cyc();
        chk("order_count", wr_log.size(), 3);
        for (int i = 0; i < wr_log.size() && i < 3; i++)
            chk($sformatf("order_%0d", i), wr_log[i], 9'(9'h0A1 + i));

        // Redirect blocks lookup, queued write goes instead
        drive(1, 9'h050, 0, 1, 9'h0B7);
        cyc();
        bus.upd_valid = 0;
        bus.redirect_valid = 1;
        settle();
        chk("redir_ready", bus.lkp_req_ready, 0);
        chk("redir_we", bus.sram_we, 1);
        chk("redir_addr", bus.sram_addr, 9'h0B7);
        adv();
        drive(0, 9'h000, 0, 0, 9'h000);
        settle();
        chk("redir_no_resp", bus.lkp_resp_valid, 0);
        adv();

        // Reset with two queued entries discards them without a write
        drive(1, 9'h060, 0, 1, 9'h0C1);
        cyc();
        drive(1, 9'h061, 0, 1, 9'h0C2);
        cyc();
        bus.upd_valid = 0;
        reset = 1'b1;
        settle();
        chk("midrst_we", bus.sram_we, 0);
        adv();
        reset = 1'b0;
        drive(0, 9'h000, 0, 0, 9'h000);
        for (int n = 0; n < 8; n++) begin
            settle();
            if (n == 0) chk("midrst_resp_vld", bus.lkp_resp_valid, 0);
            chk("midrst_no_we", bus.sram_we, 0);
            chk("midrst_upd_ready", bus.upd_ready, 1);
            adv();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1), 9'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), 9'($urandom));
            cyc();
        end
        reset = 1'b0;
        drive(0, 9'h000, 0, 0, 9'h000);
        for (int n = 0; n < 10; n++) cyc();

`ifdef BTB_PORT_ARB_PERF_EN
        settle();
        chk("perf_blk", perf_blk, 32'(m_blk));
        chk("perf_frc", perf_frc, 32'(m_frc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btb_port_arb.md
BTB_PORT_ARB -- requirements
Module: btb_port_arb

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 2, update queue entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied cycles before an update is forced.
REQ-003 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port lkp_req_valid  in  1  frontend BTB lookup request.
REQ-006 SHALL have port lkp_req_index  in  9  lookup set index.
REQ-007 SHALL have port lkp_req_ready  out  1  lookup granted this cycle.
REQ-008 SHALL have port lkp_resp_valid  out  1  SRAM read data valid this cycle.
REQ-009 SHALL have port lkp_resp_index  out  9  index of the returning lookup.
REQ-010 SHALL have port redirect_valid  in  1  frontend redirect; blocks lookup grant.
REQ-011 SHALL have port upd_valid  in  1  backend BTB update request.
REQ-012 SHALL have port upd_ready  out  1  update accepted into queue.
REQ-013 SHALL have port upd_index  in  9  update set index.
REQ-014 SHALL have port upd_wmask  in  129  update write mask.
REQ-015 SHALL have port upd_din  in  129  update write data.
REQ-016 SHALL have ports sram_ce, sram_we  out  1 each  single-port SRAM enable and write enable.
REQ-017 SHALL have ports sram_addr (9), sram_wmask (129), sram_din (129)  out  SRAM address, mask, data.

Function
REQ-018 SHALL issue at most one SRAM access per cycle; sram_ce equals the OR of lookup grant and write issue.
REQ-019 SHALL push an update when upd_valid && upd_ready; upd_ready = !full, independent of a same-cycle pop.
REQ-020 SHALL issue writes only from the queue head; there is no bypass, so the earliest write is the cycle after acceptance.
REQ-021 SHALL use FSM states NORMAL and FORCE_UPD; the reset state is NORMAL.
REQ-022 In NORMAL, lkp_req_ready SHALL equal !redirect_valid; if lkp_req_valid is also high, the lookup wins, otherwise a non-empty queue issues a write.
REQ-023 SHALL count a starve counter up each cycle the queue is non-empty and a write is not issued, and clear it on a write issue or when the queue is empty.
REQ-024 SHALL move NORMAL->FORCE_UPD when the starve counter reaches STARVE_LIMIT-1 and the write is denied again.
REQ-025 In FORCE_UPD, lkp_req_ready SHALL be 0 and the head write SHALL issue; the FSM SHALL then return to NORMAL next cycle.
REQ-026 SHALL give the SRAM read a latency of 1: a grant in cycle N yields lkp_resp_valid=1 in N+1, with lkp_resp_index equal to the index granted in N.
REQ-027 SHALL drive, on a write issue, sram_we=1, sram_addr=head index, and sram_wmask/sram_din=head entry; on a lookup, sram_we=0, sram_wmask=0, sram_addr=lkp_req_index.
REQ-028 SHALL NOT forward queued updates to lookups; a same-index lookup before the write reads the old contents.
REQ-029 SHALL wrap the queue pointers modulo UPD_DEPTH and use a count of width clog2(UPD_DEPTH)+1.
REQ-030 SHALL hold the starve counter at STARVE_LIMIT-1 (no overflow).

Reset
REQ-031 On reset, all outputs SHALL be 0, except upd_ready=1.
REQ-032 Reset SHALL empty the queue, clear the starve counter and set the FSM to NORMAL.
REQ-033 Reset SHALL suppress lkp_resp_valid in the following cycle even if a grant occurred in the reset cycle.
REQ-034 Reset asserted mid-operation SHALL discard queued updates with no SRAM write.

Configuration
REQ-035 When the macro BTB_PORT_ARB_PERF_EN is defined, SHALL add outputs perf_lkp_block_cnt (32) and perf_upd_force_cnt (32), counting lookup-valid-but-not-granted cycles and FORCE_UPD entries; both SHALL saturate and reset to 0.
REQ-036 Without BTB_PORT_ARB_PERF_EN, these ports and counters SHALL be absent, with arbitration behaviour identical.

Verification
REQ-037 SHALL cover: lkp_req_valid=1 with index 0x05 and queue empty -> lkp_req_ready=1, sram_ce=1, sram_we=0, sram_addr=0x05; next cycle lkp_resp_valid=1, lkp_resp_index=0x05.
REQ-038 SHALL cover: upd_valid=1 with index 0x1A in cycle 0 and no lookups -> sram_we=1, sram_addr=0x1A in cycle 1; queue then empty and upd_ready=1.
REQ-039 SHALL cover: one update queued with lkp_req_valid held high and STARVE_LIMIT=4 -> lookups granted in 4 cycles, then 1 forced write cycle with lkp_req_ready=0, then lookups resume.
REQ-040 SHALL cover: three back-to-back updates with UPD_DEPTH=2 and lookups saturating -> the third update sees upd_ready=0 until the first write issues, and writes occur in arrival order.
REQ-041 SHALL cover: redirect_valid=1 with lkp_req_valid=1 and one update queued -> lkp_req_ready=0, the write issues that cycle, and there is no lkp_resp_valid next cycle.
REQ-042 SHALL cover: reset pulsed while the queue holds 2 entries -> no sram_we ever issues, upd_ready=1, and lkp_resp_valid=0 the following cycle.
